// File: rtl/dmem_port_pkg.sv
// Shared definitions for the data-memory port: byte-lane mask encodings,
// FSM state encoding, default timeout and a mask legality helper.
package dmem_port_pkg;

  // Byte-lane masks as produced by the decoder for byte, half and word access.
  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  // Cycles allowed in REQ plus WAIT_R before an access is aborted.
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // True for the seven lane patterns the port can actually execute.
  function automatic logic mask_legal(input logic [3:0] mask);
    case (mask)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3,
      MASK_H0, MASK_H1, MASK_W: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_port_lsu_align.sv
// lsu_align: purely combinational lane steering shared by the port and any
// future cache path. Stores are replicated across lanes so the memory only
// needs the byte enables; loads pick the lane named by the mask and extend it.
module lsu_align
  import dmem_port_pkg::*;
(
  input  logic [3:0]  i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_wdata,
  input  logic [3:0]  i_re,
  input  logic        i_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_fill;

  // Store replication: narrow data is copied into every lane it could occupy.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    o_wdata = i_wdata;
    case (i_we)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3: o_wdata = {4{i_wdata[7:0]}};
      MASK_H0, MASK_H1:                   o_wdata = {2{i_wdata[15:0]}};
      default:                            o_wdata = i_wdata;
    endcase
  end

  // Load extraction: select the lane, then zero- or sign-extend to 32 bits.
  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    w_fill  = 1'b0;
    o_rdata = 32'h0000_0000;
    case (i_re)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3: begin
        case (i_re)
          MASK_B1: w_byte = i_rdata[15:8];
          MASK_B2: w_byte = i_rdata[23:16];
          MASK_B3: w_byte = i_rdata[31:24];
          default: w_byte = i_rdata[7:0];
        endcase
        w_fill  = ~i_unsigned & w_byte[7];
        o_rdata = {{24{w_fill}}, w_byte};
      end
      MASK_H0, MASK_H1: begin
        w_half  = (i_re == MASK_H1) ? i_rdata[31:16] : i_rdata[15:0];
        w_fill  = ~i_unsigned & w_half[15];
        o_rdata = {{16{w_fill}}, w_half};
      end
      MASK_W:  o_rdata = i_rdata;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_port.sv
// dmem_port: single-outstanding load/store controller between the decoder's
// lane masks and a valid/ready data memory. Holds the core with stall while
// the access is in flight and returns an extended load result with a
// one-cycle resp_valid pulse. Illegal masks and unresponsive memories finish
// through the same RESP cycle with err raised.
module dmem_port
  import dmem_port_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] addr,
  input  logic [3:0]  we,
  input  logic [3:0]  re,
  input  logic [31:0] wdata,
  input  logic        rd_sign,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int             CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;

  logic [31:0]   r_mem_addr;
  logic [3:0]    r_mem_we;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_re;
  logic          r_unsigned;
  logic          r_is_load;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_active;
  logic          w_illegal;
  logic          w_expired;
  logic          w_accept;
  logic          w_reject;
  logic          w_abort;
  logic          w_capture;
  logic [31:0]   w_store_data;
  logic [31:0]   w_load_data;

  // Store data is steered from the live inputs so it can be registered at
  // accept; load data is steered with the captured mask from the raw bus.
  lsu_align u_align (
    .i_we       (we),
    .i_wdata    (wdata),
    .o_wdata    (w_store_data),
    .i_re       (r_re),
    .i_unsigned (r_unsigned),
    .i_rdata    (mem_rdata),
    .o_rdata    (w_load_data)
  );

  // A request only counts when it names at least one lane; a mask that is
  // set on both sides, or is not a byte/half/word pattern, cannot execute.
  assign w_active  = req_valid && ((|we) || (|re));
  assign w_illegal = ((|we) && (|re))
                  || ((|we) && !mask_legal(we))
                  || ((|re) && !mask_legal(re));
  assign w_expired = (r_cnt == CNT_LAST);

  // Next-state and handshake outputs; memory completion wins over a timeout
  // landing in the same cycle, since the access did finish.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    w_abort    = 1'b0;
    w_capture  = 1'b0;
    stall      = 1'b0;
    mem_valid  = 1'b0;
    resp_valid = 1'b0;
    err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_active;
        if (w_active) begin
          if (w_illegal) begin
            w_reject = 1'b1;
            w_next   = ST_RESP;
          end else begin
            w_accept = 1'b1;
            w_next   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall     = 1'b1;
        mem_valid = 1'b1;
        if (mem_ready) begin
          w_next = r_is_load ? ST_WAIT_R : ST_RESP;
        end else if (w_expired) begin
          w_abort = 1'b1;
          w_next  = ST_RESP;
        end
      end
      ST_WAIT_R: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          w_capture = 1'b1;
          w_next    = ST_RESP;
        end else if (w_expired) begin
          w_abort = 1'b1;
          w_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        err        = r_err;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Timeout counter: cleared when an access enters REQ, advances while the
  // memory owes a handshake or read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == ST_REQ) || (r_state == ST_WAIT_R)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Request capture: bus fields are registered once so they stay stable for
  // the whole time mem_valid is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr  <= 32'h0000_0000;
      r_mem_we    <= 4'h0;
      r_mem_wdata <= 32'h0000_0000;
      r_re        <= 4'h0;
      r_unsigned  <= 1'b0;
      r_is_load   <= 1'b0;
    end else if (w_accept) begin
      r_mem_addr  <= addr & ~32'h0000_0003;
      r_mem_we    <= we;
      r_mem_wdata <= w_store_data;
      r_re        <= re;
      r_unsigned  <= rd_sign;
      r_is_load   <= |re;
    end
  end

  // Response capture: load data lands on the transition into RESP and is
  // held until the next response; failed accesses report zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_err   <= 1'b0;
    end else if (w_capture) begin
      r_rdata <= w_load_data;
      r_err   <= 1'b0;
    end else if (w_reject || w_abort) begin
      r_rdata <= 32'h0000_0000;
      r_err   <= 1'b1;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: a table of single accesses against a
// zero-wait memory, then hand-written wait-state, timeout, stray-rvalid,
// ignored-request and reset-during-access sequences.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [3:0]  re;
  logic [31:0] wdata;
  logic        rd_sign;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  dmem_port #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .addr       (addr),
    .we         (we),
    .re         (re),
    .wdata      (wdata),
    .rd_sign    (rd_sign),
    .stall      (stall),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .err        (err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  we;
    logic [3:0]  re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sgn;
    logic [31:0] mrdata;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here and
  // outputs are sampled one time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    addr       = 32'h0;
    we         = 4'h0;
    re         = 4'h0;
    wdata      = 32'h0;
    rd_sign    = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // One access against a memory that is always ready and returns read data
  // in the first WAIT_R cycle.
  task automatic run_vec(input vec_t v);
    logic is_load;
    is_load   = |v.re;
    req_valid = 1'b1;
    addr      = v.addr;
    we        = v.we;
    re        = v.re;
    wdata     = v.wdata;
    rd_sign   = v.sgn;
    mem_ready = 1'b1;
    #1;
    check({v.name, "_stall_T"}, 32'(stall), 32'h1);
    cyc();
    req_valid = 1'b0;
    we        = 4'h0;
    re        = 4'h0;
    #1;
    if (v.e_err) begin
      check({v.name, "_resp"},      32'(resp_valid), 32'h1);
      check({v.name, "_err"},       32'(err),        32'h1);
      check({v.name, "_mem_valid"}, 32'(mem_valid),  32'h0);
      check({v.name, "_stall"},     32'(stall),      32'h0);
    end else begin
      check({v.name, "_mem_valid"}, 32'(mem_valid), 32'h1);
      check({v.name, "_stall_T1"},  32'(stall),     32'h1);
      check({v.name, "_mem_addr"},  mem_addr,       v.e_addr);
      check({v.name, "_mem_we"},    32'(mem_we),    32'(v.e_we));
      if (!is_load) check({v.name, "_mem_wdata"}, mem_wdata, v.e_wdata);
      cyc();
      if (is_load) begin
        mem_rvalid = 1'b1;
        mem_rdata  = v.mrdata;
        #1;
        check({v.name, "_wait_resp"},  32'(resp_valid), 32'h0);
        check({v.name, "_wait_stall"}, 32'(stall),      32'h1);
        check({v.name, "_wait_valid"}, 32'(mem_valid),  32'h0);
        cyc();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
      #1;
      check({v.name, "_resp"},  32'(resp_valid), 32'h1);
      check({v.name, "_err"},   32'(err),        32'h0);
      check({v.name, "_stall"}, 32'(stall),      32'h0);
      if (is_load) check({v.name, "_rdata"}, rdata, v.e_rdata);
    end
    cyc();
    mem_ready = 1'b0;
    #1;
    check({v.name, "_resp_done"}, 32'(resp_valid), 32'h0);
    cyc();
  endtask

  initial begin
    vecs[0]  = '{name:"sw",    we:4'hF, re:4'h0, addr:32'h104,       wdata:32'hDEADBEEF, sgn:1'b0, mrdata:32'h0,
                 e_addr:32'h104,       e_we:4'hF, e_wdata:32'hDEADBEEF, e_rdata:32'h0,        e_err:1'b0};
    vecs[1]  = '{name:"sb3",   we:4'h8, re:4'h0, addr:32'h203,       wdata:32'h000000A5, sgn:1'b0, mrdata:32'h0,
                 e_addr:32'h200,       e_we:4'h8, e_wdata:32'hA5A5A5A5, e_rdata:32'h0,        e_err:1'b0};
    vecs[2]  = '{name:"sh1",   we:4'hC, re:4'h0, addr:32'h12,        wdata:32'h1234ABCD, sgn:1'b0, mrdata:32'h0,
                 e_addr:32'h10,        e_we:4'hC, e_wdata:32'hABCDABCD, e_rdata:32'h0,        e_err:1'b0};
    vecs[3]  = '{name:"sb0",   we:4'h1, re:4'h0, addr:32'h7,         wdata:32'hFFFFFF3C, sgn:1'b0, mrdata:32'h0,
                 e_addr:32'h4,         e_we:4'h1, e_wdata:32'h3C3C3C3C, e_rdata:32'h0,        e_err:1'b0};
    vecs[4]  = '{name:"lb",    we:4'h0, re:4'h4, addr:32'h102,       wdata:32'h0,        sgn:1'b0, mrdata:32'h0080FF00,
                 e_addr:32'h100,       e_we:4'h0, e_wdata:32'h0,        e_rdata:32'hFFFFFF80, e_err:1'b0};
    vecs[5]  = '{name:"lbu",   we:4'h0, re:4'h4, addr:32'h102,       wdata:32'h0,        sgn:1'b1, mrdata:32'h0080FF00,
                 e_addr:32'h100,       e_we:4'h0, e_wdata:32'h0,        e_rdata:32'h00000080, e_err:1'b0};
    vecs[6]  = '{name:"lh",    we:4'h0, re:4'hC, addr:32'h2,         wdata:32'h0,        sgn:1'b0, mrdata:32'h80010000,
                 e_addr:32'h0,         e_we:4'h0, e_wdata:32'h0,        e_rdata:32'hFFFF8001, e_err:1'b0};
    vecs[7]  = '{name:"lhu",   we:4'h0, re:4'h3, addr:32'h3FC,       wdata:32'h0,        sgn:1'b1, mrdata:32'h1234F00D,
                 e_addr:32'h3FC,       e_we:4'h0, e_wdata:32'h0,        e_rdata:32'h0000F00D, e_err:1'b0};
    vecs[8]  = '{name:"lw",    we:4'h0, re:4'hF, addr:32'h80000010, wdata:32'h0,        sgn:1'b0, mrdata:32'hCAFEF00D,
                 e_addr:32'h80000010, e_we:4'h0, e_wdata:32'h0,        e_rdata:32'hCAFEF00D, e_err:1'b0};
    vecs[9]  = '{name:"lb1",   we:4'h0, re:4'h2, addr:32'h21,        wdata:32'h0,        sgn:1'b0, mrdata:32'h00007F00,
                 e_addr:32'h20,        e_we:4'h0, e_wdata:32'h0,        e_rdata:32'h0000007F, e_err:1'b0};
    vecs[10] = '{name:"lb3",   we:4'h0, re:4'h8, addr:32'h33,        wdata:32'h0,        sgn:1'b0, mrdata:32'hC3000000,
                 e_addr:32'h30,        e_we:4'h0, e_wdata:32'h0,        e_rdata:32'hFFFFFFC3, e_err:1'b0};
    vecs[11] = '{name:"bad_re5", we:4'h0, re:4'h5, addr:32'h40,     wdata:32'h0,        sgn:1'b0, mrdata:32'h0,
                 e_addr:32'h0,         e_we:4'h0, e_wdata:32'h0,        e_rdata:32'h0,        e_err:1'b1};
    vecs[12] = '{name:"bad_both", we:4'h1, re:4'h1, addr:32'h44,    wdata:32'h0,        sgn:1'b0, mrdata:32'h0,
                 e_addr:32'h0,         e_we:4'h0, e_wdata:32'h0,        e_rdata:32'h0,        e_err:1'b1};
    vecs[13] = '{name:"bad_we6", we:4'h6, re:4'h0, addr:32'h48,     wdata:32'h0,        sgn:1'b0, mrdata:32'h0,
                 e_addr:32'h0,         e_we:4'h0, e_wdata:32'h0,        e_rdata:32'h0,        e_err:1'b1};

    // Reset values.
    idle_inputs();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    check("rst_stall",     32'(stall),      32'h0);
    check("rst_resp",      32'(resp_valid), 32'h0);
    check("rst_err",       32'(err),        32'h0);
    check("rst_mem_valid", 32'(mem_valid),  32'h0);
    check("rst_mem_we",    32'(mem_we),     32'h0);
    check("rst_rdata",     rdata,           32'h0);
    check("rst_mem_addr",  mem_addr,        32'h0);
    check("rst_mem_wdata", mem_wdata,       32'h0);
    cyc();

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // req_valid with both masks clear is not a request.
    req_valid = 1'b1;
    #1;
    check("ignored_stall", 32'(stall), 32'h0);
    cyc();
    req_valid = 1'b0;
    #1;
    check("ignored_mem_valid", 32'(mem_valid),  32'h0);
    check("ignored_resp",      32'(resp_valid), 32'h0);
    cyc();

    // Wait states: ready low for 3 REQ cycles, read data 2 cycles after handshake.
    req_valid = 1'b1;
    addr      = 32'h41;
    re        = 4'hF;
    rd_sign   = 1'b0;
    cyc();
    req_valid = 1'b0;
    re        = 4'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_valid_hold", 32'(mem_valid),  32'h1);
      check("ws_addr_hold",  mem_addr,        32'h40);
      check("ws_stall",      32'(stall),      32'h1);
      check("ws_no_resp",    32'(resp_valid), 32'h0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    check("ws_valid_hs", 32'(mem_valid), 32'h1);
    check("ws_addr_hs",  mem_addr,       32'h40);
    cyc();
    mem_ready = 1'b0;
    #1;
    check("ws_wait1_stall", 32'(stall),      32'h1);
    check("ws_wait1_valid", 32'(mem_valid),  32'h0);
    check("ws_wait1_resp",  32'(resp_valid), 32'h0);
    cyc();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h89ABCDEF;
    #1;
    check("ws_wait2_stall", 32'(stall),      32'h1);
    check("ws_wait2_resp",  32'(resp_valid), 32'h0);
    cyc();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    #1;
    check("ws_resp",  32'(resp_valid), 32'h1);
    check("ws_rdata", rdata,           32'h89ABCDEF);
    check("ws_err",   32'(err),        32'h0);
    check("ws_stall_resp", 32'(stall), 32'h0);
    cyc();
    // A stray read-data beat while idle must be ignored.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    #1;
    check("ws_single_resp", 32'(resp_valid), 32'h0);
    cyc();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    #1;
    check("stray_rvalid_resp",  32'(resp_valid), 32'h0);
    check("stray_rvalid_rdata", rdata,           32'h89ABCDEF);
    cyc();

    // Reset while waiting for read data, then a late rvalid.
    req_valid = 1'b1;
    addr      = 32'h3C4;
    re        = 4'h1;
    wdata     = 32'h55AA55AA;
    cyc();
    req_valid = 1'b0;
    re        = 4'h0;
    mem_ready = 1'b1;
    #1;
    check("rstw_req_valid", 32'(mem_valid), 32'h1);
    cyc();
    mem_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check("rstw_wait_stall", 32'(stall), 32'h1);
    cyc();
    reset      = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h000000FF;
    #1;
    check("rstw_stall",     32'(stall),      32'h0);
    check("rstw_mem_valid", 32'(mem_valid),  32'h0);
    check("rstw_resp",      32'(resp_valid), 32'h0);
    check("rstw_err",       32'(err),        32'h0);
    check("rstw_rdata",     rdata,           32'h0);
    check("rstw_mem_addr",  mem_addr,        32'h0);
    check("rstw_mem_we",    32'(mem_we),     32'h0);
    check("rstw_mem_wdata", mem_wdata,       32'h0);
    cyc();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    wdata      = 32'h0;
    #1;
    check("rstw_late_resp",  32'(resp_valid), 32'h0);
    check("rstw_late_rdata", rdata,           32'h0);
    cyc();

    // Leave a nonzero load result, then let a load time out with no ready.
    run_vec(vecs[7]);
    req_valid = 1'b1;
    addr      = 32'h500;
    re        = 4'hF;
    cyc();
    req_valid = 1'b0;
    re        = 4'h0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("to_valid_hold", 32'(mem_valid),  32'h1);
      check("to_no_resp",    32'(resp_valid), 32'h0);
      cyc();
    end
    #1;
    check("to_resp",      32'(resp_valid), 32'h1);
    check("to_err",       32'(err),        32'h1);
    check("to_mem_valid", 32'(mem_valid),  32'h0);
    check("to_rdata",     rdata,           32'h0);
    check("to_stall",     32'(stall),      32'h0);
    cyc();
    #1;
    check("to_resp_done", 32'(resp_valid), 32'h0);
    check("to_err_done",  32'(err),        32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
